// File: rtl/bus_mux_arbiter.sv
// bus_mux_arbiter: round-robin owner selection for a shared 32:1 bus mux.
// Drives registered select/enable/grant; optional burst limit per grant.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_request    [31:0] level requests, held until served
//   i_done       owner finished its transfer (only looked at in GRANT)
//   o_muxSel     [4:0] index of current (or last) owner
//   o_muxEnable  mux enable, high only while a grant is active
//   o_grant      [31:0] one-hot owner, zero when there is no owner
//   o_busy       high while in GRANT
module bus_mux_arbiter #(
    parameter int unsigned maxBurst = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_request,
    input  logic        i_done,
    output logic [4:0]  o_muxSel,
    output logic        o_muxEnable,
    output logic [31:0] o_grant,
    output logic        o_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic        LP_LIMITED = (maxBurst != 0);
    // Count value seen on the last cycle of a limited grant.
    localparam logic [15:0] LP_LAST    = 16'(maxBurst - 1);
    localparam logic [15:0] LP_SAT     = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_ptr;
    logic [15:0] r_burstCnt;

    logic        w_found;
    logic [4:0]  w_winner;
    logic        w_owner_req;
    logic        w_limit_hit;
    logic        w_release;

    logic [4:0]  w_ptr_nxt;
    logic [15:0] w_cnt_nxt;
    logic [4:0]  w_sel_nxt;
    logic        w_en_nxt;
    logic [31:0] w_grant_nxt;
    logic        w_busy_nxt;

    // Rotating priority search: first set request at r_ptr, r_ptr+1, ...
    // The 5-bit index wraps 31 -> 0 on its own.
    always_comb begin : winner_search
        logic [4:0] v_idx;
        v_idx    = '0;
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int i = 0; i < 32; i++) begin
            v_idx = r_ptr + 5'(i);
            if (!w_found && i_request[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    assign w_owner_req = i_request[o_muxSel];
    assign w_limit_hit = LP_LIMITED && (r_burstCnt == LP_LAST);
    assign w_release   = !w_owner_req || i_done || w_limit_hit;

    // State register plus the registered outputs it owns.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_burstCnt  <= '0;
            o_muxSel    <= '0;
            o_muxEnable <= 1'b0;
            o_grant     <= '0;
            o_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_burstCnt  <= w_cnt_nxt;
            o_muxSel    <= w_sel_nxt;
            o_muxEnable <= w_en_nxt;
            o_grant     <= w_grant_nxt;
            o_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and bookkeeping.
    // A release always lands in IDLE with enable low, which gives the
    // one-cycle turnaround between owners.
    always_comb begin : next_outputs
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_burstCnt;
        w_sel_nxt   = o_muxSel;
        w_en_nxt    = o_muxEnable;
        w_grant_nxt = o_grant;
        w_busy_nxt  = o_busy;
        case (r_state)
            ST_IDLE: begin
                w_en_nxt    = 1'b0;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (w_found) begin
                    w_sel_nxt   = w_winner;
                    w_grant_nxt = 32'b1 << w_winner;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // Owner drops to lowest priority for the next round.
                    w_ptr_nxt   = o_muxSel + 5'd1;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b0;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_burstCnt != LP_SAT) begin
                    w_cnt_nxt = r_burstCnt + 16'd1;
                end
            end
            default: begin
                w_en_nxt    = 1'b0;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// tb_bus_mux_arbiter: vector table, directed corner sequences and random
// stimulus against a reference model, for burst limits of 4 and 0.
module tb_bus_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        done;

    logic [4:0]  sel4, sel0;
    logic        en4, en0;
    logic [31:0] gnt4, gnt0;
    logic        busy4, busy0;

    int total = 0;
    int bad   = 0;

    bus_mux_arbiter #(.maxBurst(4)) u4 (
        .i_clock(clk), .i_reset(rst), .i_request(req), .i_done(done),
        .o_muxSel(sel4), .o_muxEnable(en4), .o_grant(gnt4), .o_busy(busy4)
    );

    bus_mux_arbiter #(.maxBurst(0)) u0 (
        .i_clock(clk), .i_reset(rst), .i_request(req), .i_done(done),
        .o_muxSel(sel0), .o_muxEnable(en0), .o_grant(gnt0), .o_busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one slot per instance: owner index or -1 when idle.
    int m_own[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_sel[2];
    int m_lim[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp4(input string nm, input logic [4:0] es,
                        input logic ee, input logic [31:0] eg);
        chk({nm, ".sel4"}, 32'(sel4), 32'(es));
        chk({nm, ".en4"}, 32'(en4), 32'(ee));
        chk({nm, ".gnt4"}, gnt4, eg);
        chk({nm, ".busy4"}, 32'(busy4), 32'(ee));
    endtask

    task automatic exp0(input string nm, input logic [4:0] es,
                        input logic ee, input logic [31:0] eg);
        chk({nm, ".sel0"}, 32'(sel0), 32'(es));
        chk({nm, ".en0"}, 32'(en0), 32'(ee));
        chk({nm, ".gnt0"}, gnt0, eg);
        chk({nm, ".busy0"}, 32'(busy0), 32'(ee));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1;
            m_ptr[k] = 0;
            m_cnt[k] = 0;
            m_sel[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [31:0] q,
                              input logic d);
        if (m_own[k] < 0) begin
            if (q != 0) begin
                for (int j = 0; j < 32; j++) begin
                    int b;
                    b = (m_ptr[k] + j) % 32;
                    if (q[b]) begin
                        m_own[k] = b;
                        m_sel[k] = b;
                        m_cnt[k] = 0;
                        break;
                    end
                end
            end
        end else begin
            if (!q[m_own[k]] || d ||
                (m_lim[k] != 0 && m_cnt[k] == m_lim[k] - 1)) begin
                m_ptr[k] = (m_own[k] + 1) % 32;
                m_own[k] = -1;
                m_cnt[k] = 0;
            end else if (m_cnt[k] < 65535) begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic model_chk(input string nm);
        logic [31:0] g[2];
        for (int k = 0; k < 2; k++)
            g[k] = (m_own[k] >= 0) ? (32'd1 << m_own[k]) : 32'd0;
        exp4(nm, 5'(m_sel[0]), m_own[0] >= 0, g[0]);
        exp0(nm, 5'(m_sel[1]), m_own[1] >= 0, g[1]);
    endtask

    // One clock: inputs sampled at the edge, outputs looked at 1ns later.
    task automatic cyc();
        logic [31:0] q;
        logic        d;
        q = req;
        d = done;
        @(posedge clk);
        model_step(0, q, d);
        model_step(1, q, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst_first;
        logic [31:0] req;
        logic        done;
        logic [4:0]  sel;
        logic        en;
        logic [31:0] gnt;
    } vec_t;

    vec_t tv[13];

    initial begin
        tv[0]  = '{1'b1, 32'h0000_0001, 1'b0, 5'd0,  1'b1, 32'h0000_0001};
        tv[1]  = '{1'b0, 32'h0000_0000, 1'b0, 5'd0,  1'b0, 32'h0000_0000};
        tv[2]  = '{1'b1, 32'h8000_0001, 1'b0, 5'd0,  1'b1, 32'h0000_0001};
        tv[3]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd0,  1'b1, 32'h0000_0001};
        tv[4]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd0,  1'b1, 32'h0000_0001};
        tv[5]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd0,  1'b1, 32'h0000_0001};
        tv[6]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd0,  1'b0, 32'h0000_0000};
        tv[7]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd31, 1'b1, 32'h8000_0000};
        tv[8]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd31, 1'b1, 32'h8000_0000};
        tv[9]  = '{1'b0, 32'h8000_0001, 1'b0, 5'd31, 1'b1, 32'h8000_0000};
        tv[10] = '{1'b0, 32'h8000_0001, 1'b0, 5'd31, 1'b1, 32'h8000_0000};
        tv[11] = '{1'b0, 32'h8000_0001, 1'b0, 5'd31, 1'b0, 32'h0000_0000};
        tv[12] = '{1'b0, 32'h8000_0001, 1'b0, 5'd0,  1'b1, 32'h0000_0001};

        m_lim[0] = 4;
        m_lim[1] = 0;
        model_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        #12;
        exp4("reset", 5'd0, 1'b0, 32'h0);
        exp0("reset", 5'd0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 13; i++) begin
            if (tv[i].rst_first) do_reset();
            req  = tv[i].req;
            done = tv[i].done;
            cyc();
            exp4($sformatf("vec%0d", i), tv[i].sel, tv[i].en, tv[i].gnt);
        end

        // Pointer wraps past 31 to 0, then moves on to 5.
        do_reset();
        req = 32'h8000_0000; cyc(); exp4("wrap.own31", 5'd31, 1'b1, 32'h8000_0000);
        req = 32'h0000_0021; cyc(); exp4("wrap.idle", 5'd31, 1'b0, 32'h0);
        cyc();               exp4("wrap.own0", 5'd0, 1'b1, 32'h1);
        req = 32'h0000_0020; cyc(); exp4("wrap.idle2", 5'd0, 1'b0, 32'h0);
        cyc();               exp4("wrap.own5", 5'd5, 1'b1, 32'h20);

        // done on the 2nd grant cycle of owner 3; pointer moves to 4.
        do_reset();
        req = 32'h0000_0008; cyc(); exp4("done.own3", 5'd3, 1'b1, 32'h8);
        cyc();               exp4("done.hold3", 5'd3, 1'b1, 32'h8);
        req = 32'h0000_0088; done = 1'b1;
        cyc();               exp4("done.idle", 5'd3, 1'b0, 32'h0);
        done = 1'b0;
        cyc();               exp4("done.own7", 5'd7, 1'b1, 32'h80);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 32'h0000_0200; cyc(); exp4("arst.own9", 5'd9, 1'b1, 32'h200);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        exp4("arst.drop", 5'd0, 1'b0, 32'h0);
        exp0("arst.drop", 5'd0, 1'b0, 32'h0);
        req = 32'h0000_0204;
        rst = 1'b0;
        cyc();               exp4("arst.own2", 5'd2, 1'b1, 32'h4);

        // Unlimited grant holds for 100 cycles.
        do_reset();
        req = 32'h0000_0400;
        for (int i = 0; i < 100; i++) begin
            cyc();
            exp0($sformatf("unlim%0d", i), 5'd10, 1'b1, 32'h400);
        end

        // Random traffic against the model, including an all-request phase.
        do_reset();
        req = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i >= 1500 && i < 1800) begin
                req = 32'hFFFF_FFFF;
            end else if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = '0;
                    1: req = 32'd1 << $urandom_range(0, 31);
                    2: req = $urandom & $urandom & $urandom;
                    default: req = $urandom;
                endcase
            end
            done = ($urandom_range(0, 7) == 0);
            cyc();
            model_chk($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
